// File: rtl/alu_pipe_pkg.sv
// Shared op encodings and flag bundle for the two-stage pipelined ALU.
package alu_pipe_pkg;
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_SHL  = 3'd5;
  localparam logic [2:0] ALU_SHR  = 3'd6;
  localparam logic [2:0] ALU_PASS = 3'd7;

  typedef struct packed {
    logic cout;
    logic zero;
    logic neg;
    logic ovf;
  } alu_flags_t;
endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU: op/a/b -> result + flags.
// Define ALU_PIPE_SAT_EN to saturate ADD/SUB to signed limits on overflow.
import alu_pipe_pkg::*;

module alu_pipe_core #(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             zero_o,
  output logic             neg_o,
  output logic             ovf_o
);
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             arith_ovf;
  logic [WIDTH-1:0] res;

  always_comb begin
    is_sub    = (op_i == ALU_SUB);
    b_eff     = is_sub ? ~b_i : b_i;
    sum       = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    // overflow when like-signed operands produce an opposite-signed sum
    arith_ovf = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
    res       = '0;
    cout_o    = 1'b0;
    ovf_o     = 1'b0;
    case (op_i)
      ALU_ADD, ALU_SUB: begin
        res    = sum[WIDTH-1:0];
        cout_o = sum[WIDTH];
        ovf_o  = arith_ovf;
`ifdef ALU_PIPE_SAT_EN
        if (arith_ovf)
          res = a_i[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
      end
      ALU_AND:  res = a_i & b_i;
      ALU_OR:   res = a_i | b_i;
      ALU_XOR:  res = a_i ^ b_i;
      ALU_SHL: begin
        res    = {a_i[WIDTH-2:0], 1'b0};
        cout_o = a_i[WIDTH-1];
      end
      ALU_SHR: begin
        res    = {1'b0, a_i[WIDTH-1:1]};
        cout_o = a_i[0];
      end
      ALU_PASS: res = b_i;
      default:  res = '0;
    endcase
    result_o = res;
    zero_o   = (res == '0);
    neg_o    = res[WIDTH-1];
  end
endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshake and full backpressure.
// Saturating ADD/SUB is selected inside alu_pipe_core via ALU_PIPE_SAT_EN.
import alu_pipe_pkg::*;

module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);
  logic             s1_v_q, s1_v_d;
  logic             s2_v_q, s2_v_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] res_q;
  alu_flags_t       flags_q;
  logic             s1_ld, s2_ld;

  logic [WIDTH-1:0] core_res;
  alu_flags_t       core_flags;

  alu_pipe_core #(.WIDTH(WIDTH)) u_core (
    .op_i     (op_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .result_o (core_res),
    .cout_o   (core_flags.cout),
    .zero_o   (core_flags.zero),
    .neg_o    (core_flags.neg),
    .ovf_o    (core_flags.ovf)
  );

  // S1 frees up whenever S2 can take its beat, so accept and drain can coincide
  always_comb begin
    in_ready = !s1_v_q || !s2_v_q || out_ready;
    s1_ld    = in_valid && in_ready;
    s2_ld    = s1_v_q && (!s2_v_q || out_ready);
    s1_v_d   = s1_ld || (s1_v_q && !s2_ld);
    s2_v_d   = s2_ld || (s2_v_q && !out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q  <= 1'b0;
      s2_v_q  <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      if (s1_ld) begin
        op_q <= op;
        a_q  <= a;
        b_q  <= b;
      end
      if (s2_ld) begin
        res_q   <= core_res;
        flags_q <= core_flags;
      end
    end
  end

  assign out_valid = s2_v_q;
  assign result    = res_q;
  assign cout      = flags_q.cout;
  assign zero      = flags_q.zero;
  assign neg       = flags_q.neg;
  assign ovf       = flags_q.ovf;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: ops/flags, latency, backpressure, reset, WIDTH=16.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [2:0] op;
  logic [7:0] a, b, result;
  logic       cout, zero, neg, ovf;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [2:0]  op16;
  logic [15:0] a16, b16, result16;
  logic        cout16, zero16, neg16, ovf16;

  int n_chk = 0;
  int n_fail = 0;
  int acc_cnt = 0;
  logic [7:0] out_q[$];

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .cout(cout), .zero(zero), .neg(neg), .ovf(ovf)
  );

  alu_pipe #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16), .op(op16),
    .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16), .result(result16),
    .cout(cout16), .zero(zero16), .neg(neg16), .ovf(ovf16)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // delivered results and accepted beats, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) out_q.push_back(result);
    if (rst_n && in_valid && in_ready) acc_cnt++;
  end

  // called just after a rising edge; returns just after the accepting edge
  task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    bit got = 1'b0;
    in_valid = 1'b1; op = o; a = x; b = y;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; break; end
    end
    if (!got) chk("issue_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic single(input string tag, input logic [2:0] o, input logic [7:0] x,
                        input logic [7:0] y, input logic [12:0] exp);
    issue(o, x, y);
    @(negedge clk);
    chk({tag, "_early"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk(tag, {out_valid, result, cout, zero, neg, ovf}, exp);
    @(posedge clk); #1;
  endtask

  task automatic wait_q(input int n);
    for (int i = 0; i < 40 && out_q.size() < n; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("q_count", out_q.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] bop[4];
    logic [7:0] ba[4], bb[4], bexp[4];
    int acc0, drop_acc;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b1; op16 = '0; a16 = '0; b16 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out", {out_valid, result, cout, zero, neg, ovf}, 13'd0);
    chk("rst_out16", {out_valid16, result16, cout16, zero16, neg16, ovf16}, 21'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    single("add_ff_01", ALU_ADD, 8'hFF, 8'h01, {1'b1, 8'h00, 4'b1100});
`ifdef ALU_PIPE_SAT_EN
    single("sub_80_01", ALU_SUB, 8'h80, 8'h01, {1'b1, 8'h80, 4'b1011});
    single("add_7f_01", ALU_ADD, 8'h7F, 8'h01, {1'b1, 8'h7F, 4'b0001});
`else
    single("sub_80_01", ALU_SUB, 8'h80, 8'h01, {1'b1, 8'h7F, 4'b1001});
    single("add_7f_01", ALU_ADD, 8'h7F, 8'h01, {1'b1, 8'h80, 4'b0011});
`endif
    single("sub_05_07", ALU_SUB, 8'h05, 8'h07, {1'b1, 8'hFE, 4'b0010});
    single("sub_07_05", ALU_SUB, 8'h07, 8'h05, {1'b1, 8'h02, 4'b1000});
    single("shr_81",    ALU_SHR, 8'h81, 8'h00, {1'b1, 8'h40, 4'b1000});
    single("shl_81",    ALU_SHL, 8'h81, 8'h00, {1'b1, 8'h02, 4'b1000});
    single("shr_01",    ALU_SHR, 8'h01, 8'h00, {1'b1, 8'h00, 4'b1100});
    single("and",       ALU_AND, 8'hF0, 8'h3C, {1'b1, 8'h30, 4'b0000});
    single("or",        ALU_OR,  8'hF0, 8'h0F, {1'b1, 8'hFF, 4'b0010});
    single("xor",       ALU_XOR, 8'hAA, 8'hAA, {1'b1, 8'h00, 4'b0100});
    single("pass",      ALU_PASS, 8'h12, 8'h80, {1'b1, 8'h80, 4'b0010});

    // backpressure: 4 back-to-back beats, sink stalled for 5 cycles
    bop  = '{ALU_ADD, ALU_SUB, ALU_XOR, ALU_AND};
    ba   = '{8'h01, 8'h10, 8'h0F, 8'hFF};
    bb   = '{8'h02, 8'h01, 8'hF0, 8'h3C};
    bexp = '{8'h03, 8'h0F, 8'hFF, 8'h3C};
    out_q.delete();
    out_ready = 1'b0;
    acc0 = acc_cnt;
    drop_acc = -1;
    fork
      begin
        for (int i = 0; i < 4; i++) issue(bop[i], ba[i], bb[i]);
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          if (!in_ready && drop_acc < 0) drop_acc = acc_cnt - acc0;
          if (k == 3) chk("bp_hold", {out_valid, result}, {1'b1, 8'h03});
        end
      end
    join
    chk("bp_drop_after", drop_acc, 2);
    wait_q(4);
    for (int i = 0; i < 4; i++)
      if (i < out_q.size()) chk($sformatf("bp_res%0d", i), out_q[i], bexp[i]);
    @(posedge clk); #1;

    // simultaneous drain and accept with both stages full
    out_q.delete();
    out_ready = 1'b0;
    issue(ALU_ADD, 8'h10, 8'h01);
    issue(ALU_ADD, 8'h20, 8'h02);
    @(negedge clk);
    chk("full_block", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid = 1'b1; op = ALU_ADD; a = 8'h30; b = 8'h03;
    #1 chk("sim_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("sim_after", {31'd0, in_ready}, 32'd1);
    wait_q(3);
    if (out_q.size() == 3) begin
      chk("sim_res0", out_q[0], 8'h11);
      chk("sim_res1", out_q[1], 8'h22);
      chk("sim_res2", out_q[2], 8'h33);
    end
    @(posedge clk); #1;

    // reset with two beats in flight
    out_ready = 1'b0;
    issue(ALU_ADD, 8'h40, 8'h04);
    issue(ALU_ADD, 8'h50, 8'h05);
    rst_n = 1'b0;
    #1 chk("rst_mid", {out_valid, result}, 9'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    out_q.delete();
    repeat (5) @(negedge clk);
    chk("rst_no_stale", out_q.size(), 0);
    chk("rst_ov_low", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    single("post_rst", ALU_ADD, 8'h01, 8'h01, {1'b1, 8'h02, 4'b0000});

    // WIDTH=16 instance
    in_valid16 = 1'b1; op16 = ALU_ADD; a16 = 16'h7FFF; b16 = 16'h0001;
    @(negedge clk);
    chk("w16_ready", {31'd0, in_ready16}, 32'd1);
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    @(posedge clk);
    @(negedge clk);
`ifdef ALU_PIPE_SAT_EN
    chk("w16_add", {out_valid16, result16, cout16, zero16, neg16, ovf16}, {1'b1, 16'h7FFF, 4'b0001});
`else
    chk("w16_add", {out_valid16, result16, cout16, zero16, neg16, ovf16}, {1'b1, 16'h8000, 4'b0011});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
